// File: rtl/reg_wb_arbiter.sv
// Two-port register-file write-back arbiter with a one-cycle registered write port.
// Define WB_ROUND_ROBIN_EN for round-robin conflict resolution; default is fixed priority to port 0.
module reg_wb_arbiter (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [4:0]  req0_addr,
  input  logic [31:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [4:0]  req1_addr,
  input  logic [31:0] req1_data,
  output logic        req1_ready,
  output logic        write,
  output logic [4:0]  regw_addr,
  output logic [31:0] regw_data,
  output logic [15:0] stall_count
);

  logic        prefer0;
  logic        stalled;
  logic        write_q, write_d;
  logic [4:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [15:0] stall_q, stall_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

`ifdef WB_ROUND_ROBIN_EN
  // last_q = 1 means port 1 won most recently, so port 0 is preferred next.
  logic last_q, last_d;

  assign prefer0 = last_q;

  always_comb begin
    last_d = last_q;
    if (req0_ready)      last_d = 1'b0;
    else if (req1_ready) last_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) last_q <= 1'b1;
    else       last_q <= last_d;
  end
`else
  assign prefer0 = 1'b1;
`endif

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!reset) begin
      req0_ready = req0_valid && (!req1_valid || prefer0);
      req1_ready = req1_valid && !req0_ready;
    end
  end

  assign stalled = (req0_valid && !req0_ready) || (req1_valid && !req1_ready);

  // Writes to x0 complete the handshake but never pulse the write enable.
  always_comb begin
    write_d = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    if (req0_ready) begin
      write_d = |req0_addr;
      addr_d  = req0_addr;
      data_d  = req0_data;
    end else if (req1_ready) begin
      write_d = |req1_addr;
      addr_d  = req1_addr;
      data_d  = req1_data;
    end
    stall_d = stalled ? sat_inc(stall_q) : stall_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      write_q <= 1'b0;
      addr_q  <= 5'd0;
      data_q  <= 32'd0;
      stall_q <= 16'd0;
    end else begin
      write_q <= write_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      stall_q <= stall_d;
    end
  end

  assign write       = write_q;
  assign regw_addr   = addr_q;
  assign regw_data   = data_q;
  assign stall_count = stall_q;

endmodule
